// File: rtl/alu_pkg.sv
// Shared opcode map, op-class helper and sequencer FSM state encoding for the
// ALU command path.
package alu_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 8;
  localparam int CMD_W  = OP_W + DATA_W;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_CMP  = 4'b0100;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0101;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SAR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_INC  = 4'b1010;
  localparam logic [OP_W-1:0] OP_DEC  = 4'b1011;
  localparam logic [OP_W-1:0] OP_NEG  = 4'b1100;
  localparam logic [OP_W-1:0] OP_MOVA = 4'b1101;
  localparam logic [OP_W-1:0] OP_SWAP = 4'b1110;
  localparam logic [OP_W-1:0] OP_LOAD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Register-file ops (A=Y, swap, load) occupy the top of the code space and
  // never produce a result beat.
  function automatic logic is_reg_op(input logic [OP_W-1:0] op);
    return (op >= OP_MOVA);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO ({op, data} entries). Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate count.
module cmd_fifo
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = CMD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push while full is ignored; flush overrides both push and pop.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign rdata = mem[rptr[AW-1:0]];

  // Pointer update: flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the signed ALU/register-file datapath: buffers host
// commands, issues one enable strobe per command, waits out the datapath
// latency and returns Y for result-producing ops over a valid/ready port.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OP_W-1:0]          cmd_op,
  input  logic signed [DATA_W-1:0] cmd_data,
  output logic [OP_W-1:0]          alu_sel,
  output logic signed [DATA_W-1:0] alu_data,
  output logic                     alu_en,
  input  logic signed [DATA_W-1:0] alu_y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [DATA_W-1:0] res_data,
  output logic [OP_W-1:0]          res_op,
  output logic                     busy,
  output logic [7:0]               op_count
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] lat_cnt;
  logic [CMD_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             lat_done;
  logic             cap_res;
  logic             done_op;

  cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata ({cmd_op, cmd_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = ~fifo_full;
  assign busy      = (state != S_IDLE) || ~fifo_empty;
  assign res_valid = (state == S_HOLD);
  assign lat_done  = (lat_cnt == CNT_W'(ALU_LAT - 1));

  // State register; async reset drops alu_en/res_valid without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control strobes; flush forces IDLE and discards any result.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap_res   = 1'b0;
    done_op   = 1'b0;
    alu_en    = (state == S_ISSUE);
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT: begin
          if (lat_done) begin
            if (is_reg_op(alu_sel)) begin
              done_op   = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              cap_res   = 1'b1;
              state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            done_op   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Issue registers: selector/data latch on pop and hold until the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_sel  <= '0;
      alu_data <= '0;
    end else if (pop) begin
      alu_sel  <= head[CMD_W-1:DATA_W];
      alu_data <= $signed(head[DATA_W-1:0]);
    end
  end

  // Datapath latency counter, running only while waiting on Y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                lat_cnt <= '0;
    else if (state != S_WAIT) lat_cnt <= '0;
    else                      lat_cnt <= lat_cnt + 1'b1;
  end

  // Result capture and completed-op counter (wraps naturally at 8 bits).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data <= '0;
      res_op   <= '0;
      op_count <= '0;
    end else begin
      if (cap_res) begin
        res_data <= alu_y;
        res_op   <= alu_sel;
      end
      if (done_op) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural ALU (latency 1) drives alu_y, an
// architectural reference model predicts issue order and results.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int ALU_LAT    = 1;

  logic              clk = 1'b0;
  logic              reset, flush, cmd_valid, cmd_ready, alu_en, res_valid, res_ready, busy;
  logic [3:0]        cmd_op, alu_sel, res_op;
  logic signed [7:0] cmd_data, alu_data, alu_y, res_data;
  logic [7:0]        op_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .alu_sel(alu_sel), .alu_data(alu_data),
    .alu_en(alu_en), .alu_y(alu_y), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .busy(busy), .op_count(op_count)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic signed [7:0] alu_result(input logic [3:0] op,
                                                    input logic signed [7:0] a,
                                                    input logic signed [7:0] b);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_CMP: return (a < b) ? -8'sd1 : ((a > b) ? 8'sd1 : 8'sd0);
      OP_XOR: return a ^ b;
      OP_NOT: return ~a;
      OP_SHL: return a <<< 1;
      OP_SHR: return $signed({1'b0, a[7:1]});
      OP_SAR: return a >>> 1;
      OP_INC: return a + 8'sd1;
      OP_DEC: return a - 8'sd1;
      OP_NEG: return -a;
      default: return 8'sd0;
    endcase
  endfunction

  // Behavioural datapath: registers A, B, Y; Y valid one cycle after alu_en.
  logic signed [7:0] dp_a, dp_b, dp_y;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_a <= 8'sd0; dp_b <= 8'sd0; dp_y <= 8'sd0;
    end else if (alu_en) begin
      case (alu_sel)
        OP_MOVA: dp_a <= dp_y;
        OP_SWAP: begin dp_a <= dp_b; dp_b <= dp_a; end
        OP_LOAD: dp_a <= alu_data;
        default: dp_y <= alu_result(alu_sel, dp_a, dp_b);
      endcase
    end
  end
  assign alu_y = dp_y;

  // Reference model: accepted-command queue, architectural A/B/Y, expected beats.
  logic [11:0]       exp_q[$];
  logic [11:0]       res_q[$];
  logic signed [7:0] sa, sb, sy;
  int                en_cnt = 0;
  int                beat_cnt = 0;

  task automatic model_clear();
    exp_q.delete(); res_q.delete();
    sa = 8'sd0; sb = 8'sd0; sy = 8'sd0;
  endtask

  task automatic model_apply(input logic [3:0] op, input logic signed [7:0] d);
    logic signed [7:0] t;
    if (op == OP_MOVA)      sa = sy;
    else if (op == OP_SWAP) begin t = sa; sa = sb; sb = t; end
    else if (op == OP_LOAD) sa = d;
    else begin
      sy = alu_result(op, sa, sb);
      res_q.push_back({op, sy});
    end
  endtask

  // Monitor, sampled mid-cycle: checks every issue and every result beat.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!reset) begin
      if (alu_en) begin
        en_cnt++;
        if (exp_q.size() == 0) check("issue_unexpected", 8'd1, 8'd0);
        else begin
          e = exp_q.pop_front();
          check("issue_sel", 8'(alu_sel), 8'(e[11:8]));
          check("issue_data", alu_data, e[7:0]);
          model_apply(e[11:8], e[7:0]);
        end
      end
      if (res_valid && res_ready && !flush) begin
        beat_cnt++;
        if (res_q.size() == 0) check("beat_unexpected", 8'd1, 8'd0);
        else begin
          e = res_q.pop_front();
          check("res_op", 8'(res_op), 8'(e[11:8]));
          check("res_data", res_data, e[7:0]);
        end
      end
      if (cmd_valid && cmd_ready && !flush) exp_q.push_back({cmd_op, cmd_data});
      if (flush) begin exp_q.delete(); res_q.delete(); end
    end
  end

  task automatic push(input logic [3:0] op, input logic [7:0] data, input bit rand_rr);
    int  t;
    bit  done;
    t = 0; done = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    while (!done && t < 200) begin
      if (rand_rr) res_ready = 1'($urandom_range(0, 1));
      @(negedge clk); done = cmd_ready;
      @(posedge clk); #1; t++;
    end
    cmd_valid = 1'b0;
    if (!done) check("push_timeout", 8'd0, 8'd1);
  endtask

  task automatic wait_idle(input int max);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || res_valid) && t < max) begin @(negedge clk); t++; end
    if (busy || res_valid) check("idle_timeout", 8'd0, 8'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_res_valid(input int max);
    int t;
    t = 0;
    @(negedge clk);
    while (!res_valid && t < max) begin @(negedge clk); t++; end
    if (!res_valid) check("res_valid_timeout", 8'd0, 8'd1);
  endtask

  initial begin
    int acc, en0, b0, bad;
    logic signed [7:0] held;
    reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_data = 8'sd0; res_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_cmd_ready", 8'(cmd_ready), 8'd1);
    check("rst_alu_en", 8'(alu_en), 8'd0);
    check("rst_res_valid", 8'(res_valid), 8'd0);
    check("rst_alu_sel", 8'(alu_sel), 8'd0);
    check("rst_res_data", res_data, 8'd0);
    check("rst_op_count", op_count, 8'd0);
    reset = 1'b0;

    // Async reset in WAIT with two commands still queued
    res_ready = 1'b0;
    push(OP_LOAD, 8'd7, 0); push(OP_ADD, 8'd1, 0); push(OP_SUB, 8'd2, 0);
    check("t1_busy_before", 8'(busy), 8'd1);
    #2 reset = 1'b1;
    #1;
    check("t1_alu_en_async", 8'(alu_en), 8'd0);
    check("t1_res_valid_async", 8'(res_valid), 8'd0);
    check("t1_busy_async", 8'(busy), 8'd0);
    model_clear();
    @(posedge clk); #1; reset = 1'b0;
    check("t1_cmd_ready", 8'(cmd_ready), 8'd1);
    check("t1_op_count", op_count, 8'd0);
    check("t1_alu_sel", 8'(alu_sel), 8'd0);
    check("t1_alu_data", alu_data, 8'd0);

    // Load/swap/load/add: one result beat of 8
    res_ready = 1'b1; b0 = beat_cnt;
    push(OP_LOAD, 8'd5, 0); push(OP_SWAP, 8'd0, 0); push(OP_LOAD, 8'd3, 0); push(OP_ADD, 8'd0, 0);
    wait_idle(100);
    check("t2_beats", 8'(beat_cnt - b0), 8'd1);
    check("t2_res_data", res_data, 8'd8);
    check("t2_res_op", 8'(res_op), 8'(OP_ADD));
    check("t2_op_count", op_count, 8'd4);

    // Signed compare: -3 vs 4, then 4 vs 4
    push(OP_LOAD, 8'd4, 0); push(OP_SWAP, 8'd0, 0); push(OP_LOAD, 8'hFD, 0); push(OP_CMP, 8'd0, 0);
    wait_idle(100);
    check("t3_cmp_lt", res_data, 8'hFF);
    push(OP_LOAD, 8'd4, 0); push(OP_CMP, 8'd0, 0);
    wait_idle(100);
    check("t3_cmp_eq", res_data, 8'h00);
    check("t3_op_count", op_count, 8'd10);

    // FIFO full under result backpressure
    res_ready = 1'b0; acc = 0; en0 = en_cnt; cmd_valid = 1'b1;
    for (int t = 0; t < 20 && acc < 6; t++) begin
      cmd_op = 4'(acc % 13); cmd_data = 8'(16 + acc);
      @(negedge clk); if (cmd_ready) acc++;
      @(posedge clk); #1;
    end
    check("t4_accepted", 8'(acc), 8'd5);
    check("t4_cmd_ready", 8'(cmd_ready), 8'd0);
    res_ready = 1'b1;
    cmd_op = 4'(acc % 13); cmd_data = 8'(16 + acc);
    for (int t = 0; t < 50 && acc < 6; t++) begin
      @(negedge clk); if (cmd_ready) acc++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_idle(200);
    check("t4_all_accepted", 8'(acc), 8'd6);
    check("t4_issued", 8'(en_cnt - en0), 8'd6);
    check("t4_drained", 8'(exp_q.size()), 8'd0);
    check("t4_op_count", op_count, 8'd16);

    // Backpressure: result held, no issue, next issue after one idle cycle
    res_ready = 1'b0;
    push(OP_LOAD, 8'd9, 0); push(OP_INC, 8'd0, 0); push(OP_SUB, 8'd0, 0);
    wait_res_valid(20);
    held = res_data; en0 = en_cnt; bad = 0;
    repeat (10) begin @(negedge clk); if (res_data !== held) bad++; end
    check("t5_res_stable", 8'(bad), 8'd0);
    check("t5_held_value", held, 8'd10);
    check("t5_no_issue", 8'(en_cnt - en0), 8'd0);
    @(posedge clk); #1; res_ready = 1'b1;
    @(negedge clk); check("t5_handshake", 8'(res_valid), 8'd1);
    @(negedge clk); check("t5_idle_gap", 8'(alu_en), 8'd0);
    @(negedge clk); check("t5_issue", 8'(alu_en), 8'd1);
    wait_idle(100);
    check("t5_op_count", op_count, 8'd19);

    // Randomized traffic with random result backpressure
    for (int i = 0; i < 150; i++) push(4'($urandom_range(0, 15)), 8'($urandom), 1);
    res_ready = 1'b1;
    wait_idle(2000);
    check("rand_op_count", op_count, 8'((19 + 150) % 256));
    check("rand_exp_empty", 8'(exp_q.size()), 8'd0);
    check("rand_res_empty", 8'(res_q.size()), 8'd0);

    // Flush in HOLD with three queued, same-cycle push dropped
    res_ready = 1'b0;
    push(OP_OR, 8'd0, 0); push(OP_LOAD, 8'd1, 0); push(OP_LOAD, 8'd2, 0); push(OP_LOAD, 8'd3, 0);
    wait_res_valid(20);
    @(posedge clk); #1;
    flush = 1'b1; cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 8'sd9;
    @(posedge clk); #1;
    flush = 1'b0; cmd_valid = 1'b0;
    check("t6_res_valid", 8'(res_valid), 8'd0);
    check("t6_busy", 8'(busy), 8'd0);
    check("t6_op_count", op_count, 8'((19 + 150) % 256));
    en0 = en_cnt;
    repeat (5) @(negedge clk);
    check("t6_no_issue", 8'(en_cnt - en0), 8'd0);
    res_ready = 1'b1;

    // op_count wrap over 256 register ops
    reset = 1'b1; model_clear();
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 255; i++) push(4'($urandom_range(13, 15)), 8'($urandom), 0);
    wait_idle(200);
    check("wrap_255", op_count, 8'd255);
    push(OP_LOAD, 8'd1, 0);
    wait_idle(50);
    check("wrap_0", op_count, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
